// File: rtl/lcd_read_if.sv
// lcd_read_if
//  Bundles the request/response handshake of the LCD read engine together
//  with the LCD-side bus pins it drives (rs/rw/en) and the data pins it
//  samples (d7..d4).
//  Signals:
//   start, rs_sel, poll   request from the write driver / user logic
//   d_in[3:0]             LCD d7..d4 as seen on the pads
//   busy, done, timeout   transaction status back to the requester
//   rd_data[7:0]          last byte read
//   bus_active, rs, rw, en  LCD control lines and pad-ownership flag
//  Modports: master = requester side (and pad model), slave = lcd_read_ctrl.
interface lcd_read_if;
   logic       start;
   logic       rs_sel;
   logic       poll;
   logic [3:0] d_in;
   logic       busy;
   logic       bus_active;
   logic       rs;
   logic       rw;
   logic       en;
   logic [7:0] rd_data;
   logic       done;
   logic       timeout;

   modport master (
      output start, rs_sel, poll, d_in,
      input  busy, bus_active, rs, rw, en, rd_data, done, timeout
   );

   modport slave (
      input  start, rs_sel, poll, d_in,
      output busy, bus_active, rs, rw, en, rd_data, done, timeout
   );
endinterface

// File: rtl/lcd_read_ctrl.sv
// lcd_read_ctrl
//  Read-side engine for an HD44780-style character LCD on its 4-bit bus.
//  Each byte is read as two enable pulses (high nibble first) with rw=1.
//  With poll set and rs_sel=0 the busy-flag register is re-read until BF
//  clears or MAX_POLLS bytes have been read, in which case timeout is
//  raised alongside done.
//  Ports:
//   clk    50 MHz system clock
//   rst_n  asynchronous active-low reset
//   bus    lcd_read_if.slave (request, status, rs/rw/en, d_in, rd_data)
//  Parameters (in clk cycles): T_AS rs/rw setup before the first en rise,
//  T_EH en high time per nibble, T_EL en low time after each nibble;
//  MAX_POLLS is the busy-flag read limit in poll mode (1..255).
module lcd_read_ctrl #(
   parameter int T_AS      = 3,
   parameter int T_EH      = 12,
   parameter int T_EL      = 14,
   parameter int MAX_POLLS = 255
) (
   input logic        clk,
   input logic        rst_n,
   lcd_read_if.slave  bus
);

   localparam int T_MAX = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                        : ((T_EH > T_EL) ? T_EH : T_EL);
   localparam int CNT_W = $clog2(T_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_AS    = CNT_W'(T_AS);
   localparam logic [CNT_W-1:0] CNT_EH_LAST = CNT_W'(T_EH - 1);
   localparam logic [CNT_W-1:0] CNT_EL_LAST = CNT_W'(T_EL - 1);
   localparam logic [7:0]       POLL_LIMIT  = 8'(MAX_POLLS);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EN_HI,
      EN_LO,
      HOLD,
      DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       poll_cnt;
   logic             rs_sel_q;
   logic             poll_q;
   logic             second_nib;
   logic [3:0]       hi_nib;
   logic [3:0]       lo_nib;

   logic             busy_r;
   logic             bus_active_r;
   logic             rs_r;
   logic             rw_r;
   logic             en_r;
   logic [7:0]       rd_data_r;
   logic             done_r;
   logic             timeout_r;

   logic [7:0]       poll_next;
   logic             bf_wait;

   // Count of bytes read including the one just completing, and whether that
   // byte asks for another busy-flag read (poll mode, BF register, BF=1).
   // poll_cnt never exceeds MAX_POLLS, so the increment cannot wrap.
   assign poll_next = poll_cnt + 8'd1;
   assign bf_wait   = poll_q & ~rs_sel_q & hi_nib[3];

   // Single sequencer for the whole read cycle. All bus pins are registered
   // so rs/rw/en change only on clock edges and never glitch. SETUP waits
   // one extra edge before its T_AS count so that rs/rw are already on the
   // pads for T_AS full cycles ahead of the first en rise. In poll mode a
   // repeated read jumps straight back to EN_HI because rs/rw are unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         poll_cnt     <= 8'd0;
         rs_sel_q     <= 1'b0;
         poll_q       <= 1'b0;
         second_nib   <= 1'b0;
         hi_nib       <= 4'h0;
         lo_nib       <= 4'h0;
         busy_r       <= 1'b0;
         bus_active_r <= 1'b0;
         rs_r         <= 1'b0;
         rw_r         <= 1'b0;
         en_r         <= 1'b0;
         rd_data_r    <= 8'h00;
         done_r       <= 1'b0;
         timeout_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  rs_sel_q  <= bus.rs_sel;
                  poll_q    <= bus.poll;
                  timeout_r <= 1'b0;
                  poll_cnt  <= 8'd0;
                  busy_r    <= 1'b1;
                  cnt       <= '0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               rs_r         <= rs_sel_q;
               rw_r         <= 1'b1;
               bus_active_r <= 1'b1;
               if (cnt == CNT_AS) begin
                  cnt        <= '0;
                  second_nib <= 1'b0;
                  en_r       <= 1'b1;
                  state      <= EN_HI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EN_HI: begin
               if (cnt == CNT_EH_LAST) begin
                  cnt  <= '0;
                  en_r <= 1'b0;
                  if (second_nib) begin
                     lo_nib <= bus.d_in;
                  end else begin
                     hi_nib <= bus.d_in;
                  end
                  state <= EN_LO;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EN_LO: begin
               if (cnt == CNT_EL_LAST) begin
                  cnt <= '0;
                  if (!second_nib) begin
                     second_nib <= 1'b1;
                     en_r       <= 1'b1;
                     state      <= EN_HI;
                  end else begin
                     rd_data_r <= {hi_nib, lo_nib};
                     poll_cnt  <= poll_next;
                     if (bf_wait && (poll_next < POLL_LIMIT)) begin
                        second_nib <= 1'b0;
                        en_r       <= 1'b1;
                        state      <= EN_HI;
                     end else begin
                        if (bf_wait) begin
                           timeout_r <= 1'b1;
                        end
                        state <= HOLD;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               rs_r         <= 1'b0;
               rw_r         <= 1'b0;
               bus_active_r <= 1'b0;
               done_r       <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_r;
   assign bus.bus_active = bus_active_r;
   assign bus.rs         = rs_r;
   assign bus.rw         = rw_r;
   assign bus.en         = en_r;
   assign bus.rd_data    = rd_data_r;
   assign bus.done       = done_r;
   assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// tb_lcd_read_ctrl
//  Scoreboard bench for lcd_read_ctrl. A pad-side LCD model serves bytes
//  from a response table, one nibble per en pulse. Each accepted request
//  pushes the expected outcome (computed from the byte table and the
//  polling rules) into a queue; a monitor pops it on every done pulse and
//  also watches en/rs/rw timing throughout the transaction.
module tb_lcd_read_ctrl;

   localparam int T_AS      = 3;
   localparam int T_EH      = 12;
   localparam int T_EL      = 14;
   localparam int MAX_POLLS = 4;
   localparam int BYTE_CYC  = 2 * (T_EH + T_EL);
   localparam int LAT_ONE   = 1 + T_AS + BYTE_CYC + 1;

   typedef struct {
      logic [7:0] data;
      bit         to;
      bit         rs;
      int         pulses;
      int         latency;
      int         accept;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   exp_t       exp_q[$];
   logic [7:0] resp[16];

   lcd_read_if bus();

   lcd_read_ctrl #(
      .T_AS      (T_AS),
      .T_EH      (T_EH),
      .T_EL      (T_EL),
      .MAX_POLLS (MAX_POLLS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 50 MHz clock and a free-running edge counter used for latency checks.
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
      end
   endtask

   // Behavioural answer for one request: walk the byte table as the LCD
   // would serve it and stop at the first byte that ends the transaction.
   task automatic refModel(input bit rs, input bit pl, output exp_t e);
      int n;
      logic [7:0] b;
      n    = 0;
      b    = 8'h00;
      e.to = 1'b0;
      e.rs = rs;
      for (int k = 1; k <= 16; k++) begin
         b = resp[k - 1];
         n = k;
         if (!(pl && !rs && b[7])) break;
         if (k == MAX_POLLS) begin
            e.to = 1'b1;
            break;
         end
      end
      e.data    = b;
      e.pulses  = 2 * n;
      e.latency = LAT_ONE + BYTE_CYC * (n - 1);
      e.accept  = 0;
   endtask

   // LCD pad model: counts completed en pulses within the current rw=1
   // window and presents the matching nibble of the response table, high
   // nibble first. Updating on the falling clock keeps d_in stable at the
   // rising edge where the controller samples it.
   int   nib_cnt = 0;
   logic en_seen = 1'b0;
   always @(negedge clk) begin
      int idx;
      if (bus.rw !== 1'b1) begin
         nib_cnt = 0;
      end else if (en_seen && !bus.en) begin
         nib_cnt = nib_cnt + 1;
      end
      en_seen = bus.en;
      idx = nib_cnt / 2;
      if (idx > 15) idx = 15;
      bus.d_in = (nib_cnt % 2 == 1) ? resp[idx][3:0] : resp[idx][7:4];
   end

   // Monitor: tracks en pulse widths, en low gaps, rs/rw setup and
   // stability while en is high, then on each done pulse pops the
   // scoreboard and compares the completed transaction.
   int   m_hi = 0;
   int   m_lo = 0;
   int   m_rw_run = 0;
   int   m_pulses = 0;
   int   m_viol = 0;
   logic m_en_p = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         m_hi = 0; m_lo = 0; m_rw_run = 0; m_pulses = 0; m_viol = 0;
         m_en_p = 1'b0;
      end else begin
         if (bus.en) begin
            if (!m_en_p) begin
               if (m_pulses == 0) begin
                  if (m_rw_run < T_AS) m_viol++;
               end else if (m_lo < T_EL) begin
                  m_viol++;
               end
               m_pulses++;
               m_hi = 0;
            end
            m_hi++;
            if (bus.rw !== 1'b1 || exp_q.size() == 0) m_viol++;
            else if (bus.rs !== exp_q[0].rs) m_viol++;
         end else begin
            if (m_en_p) begin
               if (m_hi != T_EH) m_viol++;
               m_lo = 0;
            end
            m_lo++;
         end
         if (bus.rw && !bus.en && m_pulses == 0) m_rw_run++;
         m_en_p = bus.en;
         if (bus.done) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL unexpected_done: actual 1 required 0");
            end else begin
               e = exp_q.pop_front();
               checkOutput("rd_data", bus.rd_data, e.data);
               checkOutput("timeout", bus.timeout, e.to);
               checkOutput("en_pulses", m_pulses, e.pulses);
               checkOutput("done_latency", cyc - e.accept, e.latency);
               checkOutput("bus_timing_violations", m_viol, 0);
               checkOutput("bus_released_at_done", {bus.rw, bus.en, bus.bus_active}, 0);
            end
            m_pulses = 0;
            m_rw_run = 0;
            m_viol = 0;
         end
      end
   end

   // Waits (bounded) until the controller is idle and every expected
   // transaction has been retired by the monitor.
   task automatic waitIdle();
      int n;
      n = 0;
      while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) checkOutput("idle_wait_expired", 1, 0);
   endtask

   // Issues one request, confirms acceptance on the next edge, records the
   // expected outcome, then scrambles the request inputs so only the
   // captured values can matter.
   task automatic applyStimulus(input bit rs, input bit pl);
      exp_t e;
      waitIdle();
      @(negedge clk);
      bus.start  = 1'b1;
      bus.rs_sel = rs;
      bus.poll   = pl;
      @(posedge clk);
      #1;
      checkOutput("busy_on_accept", bus.busy, 1);
      checkOutput("timeout_cleared", bus.timeout, 0);
      refModel(rs, pl, e);
      e.accept = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.rs_sel = 1'($urandom);
      bus.poll   = 1'($urandom);
   endtask

   initial begin
      int a1;
      int a2;
      int n;
      int nbf;
      exp_t e;

      bus.start  = 1'b0;
      bus.rs_sel = 1'b0;
      bus.poll   = 1'b0;
      for (int i = 0; i < 16; i++) resp[i] = 8'h00;

      #5 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  {bus.busy, bus.bus_active, bus.rs, bus.rw, bus.en, bus.done, bus.timeout}, 0);
      checkOutput("reset_rd_data", bus.rd_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Single BF/AC read.
      resp[0] = 8'hA5;
      applyStimulus(1'b0, 1'b0);
      waitIdle();

      // Data RAM read with poll requested: poll must be ignored.
      resp[0] = 8'h3C; resp[1] = 8'hFF;
      applyStimulus(1'b1, 1'b1);
      waitIdle();

      // Busy for three reads, then clear.
      resp[0] = 8'h80; resp[1] = 8'h81; resp[2] = 8'hC2; resp[3] = 8'h07;
      applyStimulus(1'b0, 1'b1);
      waitIdle();

      // Busy flag stuck: poll limit reached, timeout held afterwards.
      for (int i = 0; i < 16; i++) resp[i] = 8'h80;
      applyStimulus(1'b0, 1'b1);
      waitIdle();
      repeat (3) @(negedge clk);
      checkOutput("timeout_held", bus.timeout, 1);

      // Start pulsed mid-transaction is dropped, not queued.
      resp[0] = 8'h96;
      applyStimulus(1'b0, 1'b0);
      repeat (10) @(negedge clk);
      bus.start  = 1'b1;
      bus.rs_sel = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      waitIdle();
      repeat (4) @(negedge clk);
      checkOutput("busy_start_ignored", bus.busy, 0);

      // Reset in the middle of the second nibble's enable pulse.
      resp[0] = 8'hE1;
      applyStimulus(1'b1, 1'b0);
      repeat (33) @(posedge clk);
      #1;
      checkOutput("en_high_before_reset", bus.en, 1);
      #4 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_bus", {bus.en, bus.rw, bus.bus_active, bus.busy}, 0);
      checkOutput("async_reset_rd_data", bus.rd_data, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      resp[0] = 8'h5A;
      applyStimulus(1'b0, 1'b0);
      waitIdle();

      // Start held high: the next transaction begins on the first idle edge.
      waitIdle();
      resp[0] = 8'h3C;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.rs_sel = 1'b1;
      bus.poll   = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("busy_on_accept", bus.busy, 1);
      refModel(1'b1, 1'b0, e);
      a1 = cyc;
      e.accept = a1;
      exp_q.push_back(e);
      n = 0;
      while (bus.busy !== 1'b0 && n < 500) begin
         @(posedge clk); #1; n++;
      end
      while (bus.busy !== 1'b1 && n < 500) begin
         @(posedge clk); #1; n++;
      end
      a2 = cyc;
      checkOutput("restart_gap", a2 - a1, LAT_ONE + 2);
      e.accept = a2;
      exp_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      waitIdle();

      // Randomised requests.
      for (int t = 0; t < 20; t++) begin
         bit rs;
         bit pl;
         rs  = 1'($urandom);
         pl  = 1'($urandom);
         nbf = $urandom_range(0, 5);
         for (int i = 0; i < 16; i++) begin
            if (rs) resp[i] = 8'($urandom);
            else if (i < nbf) resp[i] = 8'h80 | 8'($urandom_range(0, 127));
            else if (i == nbf) resp[i] = 8'($urandom_range(0, 127));
            else resp[i] = 8'($urandom);
         end
         applyStimulus(rs, pl);
         waitIdle();
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global bound on simulated time.
   initial begin
      #2ms;
      $display("[TB] FAIL global_timeout: actual expired required finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
